i2c_cfg_seq: RTL and testbench

Configuration sequencer for the audio-codec I2C path. After reset or on a `start` pulse, it walks a fixed table of 16-bit codec register words (7-bit register address, 9-bit value). It hands each word to the I2C master through a one-cycle request/busy handshake. A NACKed word is retried up to a limit, and an enforced idle gap separates transfers. It sits between the board control logic (key/auto-start) and the I2C master, driving that master's `ts` and `data` inputs.

---
 rtl/i2c_cfg_seq_pkg.sv | 35 +++
 rtl/i2c_cfg_rom.sv | 37 +++
 rtl/i2c_cfg_seq.sv | 132 +++++++++++++
 tb/tb_i2c_cfg_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_seq_pkg.sv
// Shared definitions for the codec configuration sequencer: FSM state encodings,
// codec register addresses and the {reg, value} word layout handed to the I2C master.
package i2c_cfg_seq_pkg;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ISSUE       = 3'd1;
    localparam logic [2:0] S_WAIT_ACCEPT = 3'd2;
    localparam logic [2:0] S_WAIT_DONE   = 3'd3;
    localparam logic [2:0] S_GAP         = 3'd4;
    localparam logic [2:0] S_DONE        = 3'd5;
    localparam logic [2:0] S_ERROR       = 3'd6;

    localparam logic [6:0] REG_LINE_IN      = 7'h00;
    localparam logic [6:0] REG_HP_OUT       = 7'h02;
    localparam logic [6:0] REG_ANALOG_PATH  = 7'h04;
    localparam logic [6:0] REG_DIGITAL_PATH = 7'h05;
    localparam logic [6:0] REG_POWER        = 7'h06;
    localparam logic [6:0] REG_FORMAT       = 7'h07;
    localparam logic [6:0] REG_SAMPLING     = 7'h08;
    localparam logic [6:0] REG_ACTIVE       = 7'h09;
    localparam logic [6:0] REG_RESET        = 7'h0F;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] val;
    } cfg_word_t;

    function automatic cfg_word_t cfg_word(input logic [6:0] addr, input logic [8:0] val);
        cfg_word_t w;
        w.addr = addr;
        w.val  = val;
        return w;
    endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Codec register table: word_index -> {reg[6:0], val[8:0]}, reset first, activate last.
// Latency: combinational, no registers.
// Backpressure: none; entries at or beyond NUM_WORDS read as zero.
module i2c_cfg_rom
    import i2c_cfg_seq_pkg::*;
#(
    parameter int NUM_WORDS = 10
) (
    input  logic [3:0]  word_index,
    output logic [15:0] word
);

    cfg_word_t entry;

    always_comb begin
        entry = '0;
        case (word_index)
            4'd0:    entry = cfg_word(REG_RESET,        9'h000);
            4'd1:    entry = cfg_word(REG_POWER,        9'h010);
            4'd2:    entry = cfg_word(REG_LINE_IN,      9'h017);
            4'd3:    entry = cfg_word(REG_HP_OUT,       9'h079);
            4'd4:    entry = cfg_word(REG_ANALOG_PATH,  9'h012);
            4'd5:    entry = cfg_word(REG_DIGITAL_PATH, 9'h000);
            4'd6:    entry = cfg_word(REG_FORMAT,       9'h042);
            4'd7:    entry = cfg_word(REG_SAMPLING,     9'h000);
            4'd8:    entry = cfg_word(REG_POWER,        9'h000);
            4'd9:    entry = cfg_word(REG_ACTIVE,       9'h001);
            default: entry = '0;
        endcase
        // Shorter configurations truncate the table rather than reindex it.
        if (32'(word_index) >= NUM_WORDS)
            entry = '0;
    end

    assign word = entry;

endmodule

// File: rtl/i2c_cfg_seq.sv
// Walks the codec register table, handing one word at a time to the I2C master with NACK/timeout retry.
// Latency: ts one clock after start is sampled; outcome evaluated on the first busy-low clock, gap follows.
// Backpressure: waits on xfer_busy; start is ignored while cfg_busy, timeout bounds a silent master.
module i2c_cfg_seq
    import i2c_cfg_seq_pkg::*;
#(
    parameter int NUM_WORDS      = 10,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 1000,
    parameter int ACCEPT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        xfer_busy,
    input  logic        xfer_nack,
    output logic        ts,
    output logic [15:0] data,
    output logic [3:0]  word_index,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error
);

    localparam int TW = (ACCEPT_TIMEOUT < 2) ? 1 : $clog2(ACCEPT_TIMEOUT);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    // The ts clock counts toward the timeout, so WAIT_ACCEPT gets ACCEPT_TIMEOUT-1 clocks.
    localparam logic [TW-1:0] TMO_LAST = TW'((ACCEPT_TIMEOUT < 2) ? 0 : ACCEPT_TIMEOUT - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]    state;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    rom_addr;
    logic [15:0]   rom_word;
    logic          accept_expired;
    logic          attempt_ok;
    logic          attempt_fail;
    logic          last_word;
    logic          can_start;

    // Only GAP re-issues the current index; every other ISSUE entry is a fresh start at word 0.
    assign rom_addr = (state == S_GAP) ? word_index : 4'd0;

    i2c_cfg_rom #(
        .NUM_WORDS (NUM_WORDS)
    ) u_rom (
        .word_index (rom_addr),
        .word       (rom_word)
    );

    assign accept_expired = (state == S_WAIT_ACCEPT) && !xfer_busy && (tmo_cnt == TMO_LAST);
    assign attempt_ok     = (state == S_WAIT_DONE) && !xfer_busy && !xfer_nack;
    assign attempt_fail   = accept_expired || ((state == S_WAIT_DONE) && !xfer_busy && xfer_nack);
    assign last_word      = (word_index == 4'(NUM_WORDS - 1));
    assign can_start      = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ts         <= 1'b0;
            data       <= '0;
            word_index <= '0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            ts <= 1'b0;
            if (can_start) begin
                state      <= S_ISSUE;
                ts         <= 1'b1;
                data       <= rom_word;
                word_index <= '0;
                retry_cnt  <= '0;
                cfg_busy   <= 1'b1;
                cfg_done   <= 1'b0;
                cfg_error  <= 1'b0;
            end else if (attempt_ok) begin
                if (last_word) begin
                    state    <= S_DONE;
                    cfg_busy <= 1'b0;
                    cfg_done <= 1'b1;
                end else begin
                    state      <= S_GAP;
                    word_index <= word_index + 4'd1;
                    retry_cnt  <= '0;
                    gap_cnt    <= '0;
                end
            end else if (attempt_fail) begin
                if (retry_cnt < RW'(MAX_RETRY)) begin
                    state     <= S_GAP;
                    retry_cnt <= retry_cnt + RW'(1);
                    gap_cnt   <= '0;
                end else begin
                    state     <= S_ERROR;
                    cfg_busy  <= 1'b0;
                    cfg_error <= 1'b1;
                end
            end else begin
                case (state)
                    S_ISSUE: begin
                        state   <= S_WAIT_ACCEPT;
                        tmo_cnt <= '0;
                    end
                    S_WAIT_ACCEPT: begin
                        if (xfer_busy)
                            state <= S_WAIT_DONE;
                        else if (tmo_cnt != '1)
                            tmo_cnt <= tmo_cnt + TW'(1);
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= S_ISSUE;
                            ts    <= 1'b1;
                            data  <= rom_word;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// Bench for i2c_cfg_seq: a reactive I2C master stub, a timeline model of each run's attempts,
// and one compare process checking every cycle plus literal pinned expectations.
module tb_i2c_cfg_seq;

    localparam int NW       = 10;
    localparam int MR       = 3;
    localparam int GAP      = 1000;
    localparam int TMO      = 64;
    localparam int BUSY_LEN = 30;
    localparam int PER      = BUSY_LEN + 1 + GAP;   // ts-to-ts spacing with an ACKing master

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic        xfer_busy = 1'b0;
    logic        xfer_nack = 1'b0;
    logic        ts;
    logic [15:0] data;
    logic [3:0]  word_index;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;

    i2c_cfg_seq #(
        .NUM_WORDS      (NW),
        .MAX_RETRY      (MR),
        .GAP_CYCLES     (GAP),
        .ACCEPT_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .xfer_busy  (xfer_busy),
        .xfer_nack  (xfer_nack),
        .ts         (ts),
        .data       (data),
        .word_index (word_index),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ts;
        logic [15:0] data;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    typedef struct {
        int          at;
        int          sel;
        logic [31:0] val;
    } pin_t;

    // Planned run: one record per attempt (issue cycle, word, outcome, first cycle after evaluation).
    int         ts_c  [64];
    int         end_c [64];
    logic [3:0] idx_a [64];
    bit         ok_a  [64];
    bit         nack_a[64];
    int         n_att       = 0;
    int         first_ts    = 0;
    bit         have_plan   = 1'b0;
    bit         accept_mode = 1'b1;
    obs_t       snap        = '0;
    pin_t       pins[$];

    function automatic logic [15:0] rom_word(input logic [3:0] i);
        case (i)
            4'd0:    return 16'h1E00;
            4'd1:    return 16'h0C10;
            4'd2:    return 16'h0017;
            4'd3:    return 16'h0479;
            4'd4:    return 16'h0812;
            4'd5:    return 16'h0A00;
            4'd6:    return 16'h0E42;
            4'd7:    return 16'h1000;
            4'd8:    return 16'h0C00;
            4'd9:    return 16'h1201;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic obs_t expect_at(input int t);
        obs_t o;
        int   k;
        bit   after;
        bit   last;
        o      = snap;
        o.ts   = 1'b0;
        o.busy = 1'b0;
        if (!have_plan || t < first_ts)
            return o;
        k = 0;
        for (int j = 0; j < n_att; j++)
            if (ts_c[j] <= t) k = j;
        after  = (t >= end_c[k]);
        last   = (k == n_att - 1);
        o.ts   = (t == ts_c[k]);
        o.data = rom_word(idx_a[k]);
        o.idx  = idx_a[k];
        if (after && ok_a[k] && idx_a[k] != 4'(NW - 1))
            o.idx = idx_a[k] + 4'd1;
        o.busy = !(after && last);
        o.done = after && last && ok_a[k];
        o.err  = after && last && !ok_a[k];
        return o;
    endfunction

    function automatic logic [31:0] field(input int sel);
        case (sel)
            0:       return 32'(ts);
            1:       return 32'(data);
            2:       return 32'(word_index);
            3:       return 32'(cfg_busy);
            4:       return 32'(cfg_done);
            default: return 32'(cfg_error);
        endcase
    endfunction

    function automatic string field_name(input int sel);
        case (sel)
            0:       return "ts";
            1:       return "data";
            2:       return "word_index";
            3:       return "cfg_busy";
            4:       return "cfg_done";
            default: return "cfg_error";
        endcase
    endfunction

    // Single compare process: whole-output check against the model (or reset values) and pinned literals.
    always @(negedge clk) begin
        obs_t        e;
        obs_t        a;
        logic [31:0] v;
        a = {ts, data, word_index, cfg_busy, cfg_done, cfg_error};
        e = reset_n ? expect_at(cyc) : obs_t'('0);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got ts=%b data=%h idx=%0d busy=%b done=%b err=%b, expected ts=%b data=%h idx=%0d busy=%b done=%b err=%b",
                     reset_n ? "model" : "reset_values", cyc, a.ts, a.data, a.idx, a.busy, a.done, a.err,
                     e.ts, e.data, e.idx, e.busy, e.done, e.err);
        end
        foreach (pins[i]) begin
            if (pins[i].at == cyc) begin
                v = field(pins[i].sel);
                checks++;
                if (v !== pins[i].val) begin
                    errors++;
                    $display("FAIL pin_%s cycle %0d: got %0h, expected %0h",
                             field_name(pins[i].sel), cyc, v, pins[i].val);
                end
            end
        end
    end

    // I2C master stub: busy rises in the ts clock, stays high BUSY_LEN clocks, NACK per plan.
    initial begin
        bit nack_now;
        forever begin
            @(posedge clk); #1;
            if (ts === 1'b1 && accept_mode) begin
                nack_now = 1'b0;
                for (int k = 0; k < n_att; k++)
                    if (have_plan && ts_c[k] == cyc) nack_now = nack_a[k];
                xfer_busy = 1'b1;
                repeat (BUSY_LEN - 1) begin @(posedge clk); #1; end
                @(posedge clk); #1;
                xfer_busy = 1'b0;
                xfer_nack = nack_now;
                @(posedge clk); #1;
                xfer_nack = 1'b0;
            end
        end
    end

    task automatic add_pin(input int at, input int sel, input logic [31:0] val);
        pin_t p;
        p.at  = at;
        p.sel = sel;
        p.val = val;
        pins.push_back(p);
    endtask

    task automatic plan_run(input int s, input bit acc, input int nack_word, input int nack_cnt);
        int t;
        int idx;
        int r;
        bit fail;
        snap        = expect_at(s);
        n_att       = 0;
        t           = s + 1;
        idx         = 0;
        r           = 0;
        first_ts    = s + 1;
        accept_mode = acc;
        for (int k = 0; k < 64; k++) begin
            fail      = !acc || (idx == nack_word && r < nack_cnt);
            ts_c[k]   = t;
            idx_a[k]  = 4'(idx);
            ok_a[k]   = !fail;
            nack_a[k] = acc && fail;
            end_c[k]  = acc ? t + BUSY_LEN + 1 : t + TMO;
            n_att     = k + 1;
            if (!fail) begin
                if (idx == NW - 1) break;
                idx++;
                r = 0;
            end else begin
                if (r == MR) break;
                r++;
            end
            t = end_c[k] + GAP;
        end
        have_plan = 1'b1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic go(input bit acc, input int nack_word, input int nack_cnt, output int s);
        @(posedge clk); #1;
        s = cyc;
        plan_run(s, acc, nack_word, nack_cnt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3;
        reset_n   = 1'b0;
        have_plan = 1'b0;
        snap      = '0;
        add_pin(cyc, 0, 32'h0);
        add_pin(cyc, 3, 32'h0);
        add_pin(cyc, 1, 32'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    initial begin
        int s;
        int t;

        // Power-on reset, then idle: no ts without start
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        for (int f = 0; f < 6; f++) add_pin(cyc + 2, f, 32'h0);
        wait_until(cyc + 20);

        // Nominal run with a start re-pulse during the gap after word 2
        go(1'b1, 99, 0, s);
        add_pin(s + 1, 0, 32'h1);
        add_pin(s + 1, 1, 32'h1E00);
        add_pin(s + 1031, 0, 32'h0);
        add_pin(s + 1032, 0, 32'h1);
        add_pin(s + 1032, 1, 32'h0C10);
        add_pin(s + 1 + 3 * 1031, 2, 32'h3);
        add_pin(s + 1 + 3 * 1031, 1, 32'h0479);
        add_pin(s + 9310, 4, 32'h0);
        add_pin(s + 9311, 4, 32'h1);
        add_pin(s + 9311, 3, 32'h0);
        add_pin(s + 9311, 2, 32'h9);
        wait_until(s + 1 + 2 * PER + 40);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_until(s + 1 + 9 * PER + 31 + 10);

        // Word 3 NACKed once
        go(1'b1, 3, 1, s);
        t = s + 1 + 3 * PER;
        add_pin(t, 0, 32'h1);
        add_pin(t, 1, 32'h0479);
        add_pin(t + 31, 2, 32'h3);
        add_pin(t + PER, 0, 32'h1);
        add_pin(t + PER, 1, 32'h0479);
        add_pin(t + PER, 2, 32'h3);
        add_pin(s + 1 + 10 * PER + 31, 4, 32'h1);
        wait_until(s + 1 + 10 * PER + 31 + 10);

        // Word 5 NACKed on every attempt
        go(1'b1, 5, 4, s);
        t = s + 1 + 8 * PER + 31;
        add_pin(t - 1, 5, 32'h0);
        add_pin(t, 5, 32'h1);
        add_pin(t, 2, 32'h5);
        add_pin(t, 4, 32'h0);
        wait_until(t + 2000);

        // Restart from error, then reset during WAIT_DONE of word 2
        go(1'b1, 99, 0, s);
        add_pin(s, 5, 32'h1);
        add_pin(s + 1, 5, 32'h0);
        add_pin(s + 1, 2, 32'h0);
        add_pin(s + 1, 0, 32'h1);
        wait_until(s + 1 + 2 * PER + 10);
        pulse_reset();
        wait_until(cyc + 1500);

        // Master never accepts: four timeouts, then error
        go(1'b0, 99, 0, s);
        add_pin(s + 1 + 1064, 0, 32'h1);
        add_pin(s + 1 + 1064, 1, 32'h1E00);
        t = s + 1 + 3 * 1064 + 64;
        add_pin(t - 1, 5, 32'h0);
        add_pin(t, 5, 32'h1);
        add_pin(t, 2, 32'h0);
        wait_until(t + 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
